// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle MIPS core: req/ack memory access, IR/MDR latches.
// Optional access timeout with sticky bus_err when ACCESS_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [5:0]        op,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                rd_q, rd_d;
  logic                to_ir_q, to_ir_d;
  logic                access;
  logic [ADDR_W-3:0]   word_sel;
  logic                unused_addr_lsb;

  assign access          = mem_read | mem_write;
  assign word_sel        = iord ? alu_out[ADDR_W-1:2]
                                : pc[ADDR_W-1:2];
  assign unused_addr_lsb = ^{pc[1:0], alu_out[1:0]};

`ifdef ACCESS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       berr_q, berr_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    rd_d    = rd_q;
    to_ir_d = to_ir_q;
`ifdef ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
    berr_d  = berr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {word_sel, 2'b00};
          wdata_d = wdata;
          rd_d    = ~mem_write;
          to_ir_d = ir_write;
`ifdef ACCESS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (m_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (rd_q) begin
            if (to_ir_q) ir_d  = m_rdata;
            else         mdr_d = m_rdata;
          end
        end
`ifdef ACCESS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Abort: nothing captured, controller released via DONE
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      rd_q    <= 1'b0;
      to_ir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      rd_q    <= rd_d;
      to_ir_q <= to_ir_d;
    end
  end

`ifdef ACCESS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign bus_err = berr_q;
`else
  assign bus_err = 1'b0;
`endif

  // Controller advances on the DONE-cycle edge
  assign stall   = access & (state_q != DONE);
  assign ir      = ir_q;
  assign mdr     = mdr_q;
  assign op      = ir_q[DATA_W-1:DATA_W-6];
  assign m_req   = req_q;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses, reset abort, idle ack.
// Timeout scenario runs when ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

`ifdef ACCESS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ir_write, iord;
  logic [31:0] pc, alu_out, wdata;
  logic        stall;
  logic [31:0] ir, mdr;
  logic [5:0]  op;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ack;
  logic        bus_err;

  mem_access_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .iord(iord),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .stall(stall), .ir(ir), .mdr(mdr), .op(op),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        berr;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  logic [31:0] exp_ir   = '0;
  logic [31:0] exp_mdr  = '0;
  logic        exp_berr = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", n, act, exp);
    else
      passed++;
  endtask

  // Monitor: a falling m_req marks the DONE cycle of a transaction
  logic        prev_req = 1'b0;
  int          scnt     = 0;
  logic [31:0] rise_addr, last_addr, rise_wd;
  logic        rise_we;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      scnt     = 0;
    end else begin
      if (stall) scnt++;
      if (m_req && !prev_req) begin
        rise_addr = m_addr;
        rise_we   = m_we;
        rise_wd   = m_wdata;
      end
      if (m_req) last_addr = m_addr;
      if (!m_req && prev_req) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("m_addr",      rise_addr, e.addr);
          chk("m_addr_hold", last_addr, e.addr);
          chk("m_we",        {31'd0, rise_we}, {31'd0, e.we});
          chk("m_wdata",     rise_wd, e.wd);
          chk("ir",          ir, e.ir);
          chk("op",          {26'd0, op}, {26'd0, e.ir[31:26]});
          chk("mdr",         mdr, e.mdr);
          chk("bus_err",     {31'd0, bus_err}, {31'd0, e.berr});
          chk("stall_done",  {31'd0, stall}, 32'd0);
          chk("stall_cycles", scnt, e.stalls);
        end
        scnt = 0;
      end
      prev_req = m_req;
    end
  end

  task automatic access(input logic rd, input logic wr,
                        input logic irw, input logic io,
                        input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] rdata, input bit ack_en);
    exp_t e;
    int   n;
    e.addr = (io ? a : p) & 32'hFFFF_FFFC;
    e.we   = wr;
    e.wd   = wd;
    if (ack_en && !wr) begin
      if (irw) exp_ir  = rdata;
      else     exp_mdr = rdata;
    end
    if (!ack_en) exp_berr = 1'b1;
    e.ir     = exp_ir;
    e.mdr    = exp_mdr;
    e.berr   = exp_berr;
    e.stalls = ack_en ? 2 + waits : 1 + TO;
    sb.push_back(e);
    n = ack_en ? waits : TO - 1;

    @(posedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    ir_write  = irw;
    iord      = io;
    pc        = p;
    alu_out   = a;
    wdata     = wd;
    @(posedge clk); #1;
    // Inputs change mid-transaction; the access must not notice
    pc       = p ^ 32'h0000_0F00;
    alu_out  = a ^ 32'h0000_0F00;
    wdata    = ~wd;
    iord     = ~io;
    ir_write = ~irw;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    if (ack_en) begin
      m_ack   = 1'b1;
      m_rdata = rdata;
    end
    @(posedge clk); #1;
    m_ack   = 1'b0;
    m_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    pc        = '0;
    alu_out   = '0;
    wdata     = '0;
    m_rdata   = '0;
    m_ack     = 1'b0;
    #2;
    chk("rst_m_req",  {31'd0, m_req}, 32'd0);
    chk("rst_m_we",   {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_ir",     ir, 32'd0);
    chk("rst_mdr",    mdr, 32'd0);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    chk("rst_berr",   {31'd0, bus_err}, 32'd0);
    #5 rst = 1'b0;

    // Fetch, zero wait
    access(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 0, 32'h8C22_0004, 1);
    // Load, 3 wait states, unaligned ALUOut
    access(1, 0, 0, 1, 32'h44, 32'h107, 32'h0, 3, 32'h1234_5678, 1);
    // Store: both strobes high
    access(1, 1, 0, 1, 32'h48, 32'h200, 32'hDEAD_BEEF, 1,
           32'hFFFF_FFFF, 1);
    // Fetch from unaligned PC, 2 waits
    access(1, 0, 1, 0, 32'h45, 32'h0, 32'h1111_2222, 2,
           32'hAC43_0008, 1);

    // Reset during BUSY, then a late ack
    @(posedge clk); #1;
    mem_read = 1'b1;
    ir_write = 1'b1;
    pc       = 32'h80;
    @(posedge clk); #1;
    chk("busy_m_req", {31'd0, m_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_m_req", {31'd0, m_req}, 32'd0);
    mem_read = 1'b0;
    ir_write = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_ir   = '0;
    exp_mdr  = '0;
    exp_berr = 1'b0;
    m_ack    = 1'b1;
    m_rdata  = 32'h5555_5555;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("late_ack_ir",    ir, 32'd0);
    chk("late_ack_mdr",   mdr, 32'd0);
    chk("late_ack_m_req", {31'd0, m_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);

    // Ack while idle, no request
    access(1, 0, 0, 1, 32'h0, 32'h10, 32'h0, 0, 32'h0000_00F0, 1);
    @(posedge clk); #1;
    m_ack   = 1'b1;
    m_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);
    chk("idle_ack_m_req", {31'd0, m_req}, 32'd0);
    chk("idle_ack_ir",    ir, exp_ir);
    chk("idle_ack_mdr",   mdr, exp_mdr);
    @(posedge clk); #1;
    chk("idle_ack_m_req2", {31'd0, m_req}, 32'd0);

`ifdef ACCESS_TIMEOUT_EN
    // No ack: abort after TO BUSY cycles, bus_err sticky
    access(1, 0, 0, 1, 32'h0, 32'h300, 32'h0, 0, 32'h0, 0);
    access(1, 0, 0, 1, 32'h0, 32'h304, 32'h0, 0, 32'h0BAD_F00D, 1);
    chk("berr_sticky", {31'd0, bus_err}, 32'd1);
    rst = 1'b1;
    #1;
    chk("berr_rst", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
